neuron_sched: RTL and testbench

NEURON_SCHED -- requirements
Module: neuron_sched

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/sat_step.sv | 23 ++
 rtl/neuron_sched.sv | 136 +++++++++++++
 tb/tb_neuron_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding, datapath width and saturation limits
// for the neuron_sched integrate-and-fire scheduler.
// The LEARN state exists only when STDP_LEARN_EN is defined.
package neuron_pkg;

    localparam int W = 8;

    localparam logic [W-1:0] SAT_MIN = 8'd0;
    localparam logic [W-1:0] SAT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        LEAK,
        ACCUM,
        FIRE
`ifdef STDP_LEARN_EN
        , LEARN
`endif
    } state_t;

endpackage

// File: rtl/sat_step.sv
// sat_step: 8-bit saturating add (sub=0) or subtract (sub=1).
// Shared by potential accumulation and the STDP weight update.
module sat_step
    import neuron_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    logic [W:0] sum;

    // Clamp to SAT_MAX on carry-out and to SAT_MIN on borrow
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        if (sub)
            y = (a < b) ? SAT_MIN : a - b;
        else
            y = sum[W] ? SAT_MAX : sum[W-1:0];
    end

endmodule

// File: rtl/neuron_sched.sv
// neuron_sched: one leaky integrate-and-fire neuron with N_IN synapses.
// A tick runs LEAK -> ACCUM (one synapse per cycle) -> FIRE and, when
// STDP_LEARN_EN is defined and the step fired with learn set, a LEARN
// pass that nudges each weight toward the latched input pattern.
module neuron_sched
    import neuron_pkg::*;
#(
    parameter int           N_IN        = 8,
    parameter logic [W-1:0] THRESH      = 8'd128,
    parameter int           LEAK_SHIFT  = 2,
    parameter logic [W-1:0] WEIGHT_INIT = 8'd16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_in,
    input  logic [N_IN-1:0] inputs,
    input  logic            learn,
    input  logic            w_we,
    input  logic [2:0]      w_addr,
    input  logic [W-1:0]    w_data,
    output logic            busy,
    output logic            spike_out,
    output logic            done,
    output logic [W-1:0]    potential,
    output logic            overrun
);

    localparam int            IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

    state_t                   state, state_nx;
    logic [IW-1:0]            idx;
    logic [N_IN-1:0]          in_q;
    logic [N_IN-1:0][W-1:0]   weight;
    logic [W-1:0]             pot;
    logic [W-1:0]             acc_sum;
    logic                     fire;

    assign fire      = (pot >= THRESH);
    assign busy      = (state != IDLE);
    assign potential = pot;

    sat_step u_acc (.a(pot), .b(weight[idx]), .sub(1'b0), .y(acc_sum));

`ifdef STDP_LEARN_EN
    logic         learn_q;
    logic [W-1:0] w_nx;

    // Potentiate active synapses, depress silent ones
    sat_step u_lrn (.a(weight[idx]), .b(W'(1)), .sub(~in_q[idx]), .y(w_nx));
`else
    logic unused_learn;
    assign unused_learn = learn;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (tick_in) state_nx = LEAK;
            LEAK:  state_nx = ACCUM;
            ACCUM: if (idx == LAST) state_nx = FIRE;
`ifdef STDP_LEARN_EN
            FIRE:  state_nx = (fire && learn_q) ? LEARN : IDLE;
            LEARN: if (idx == LAST) state_nx = IDLE;
`else
            FIRE:  state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latches, potential, weights, pulses and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pot       <= '0;
            idx       <= '0;
            in_q      <= '0;
            spike_out <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_IN; i++) weight[i] <= WEIGHT_INIT;
`ifdef STDP_LEARN_EN
            learn_q   <= 1'b0;
`endif
        end else begin
            spike_out <= 1'b0;
            done      <= 1'b0;
            if (tick_in && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    // A write coinciding with tick lands before ACCUM reads it
                    if (w_we && int'(w_addr) < N_IN) weight[w_addr] <= w_data;
                    if (tick_in) begin
                        in_q <= inputs;
                        idx  <= '0;
`ifdef STDP_LEARN_EN
                        learn_q <= learn;
`endif
                    end
                end
                LEAK: pot <= pot - (pot >> LEAK_SHIFT);
                ACCUM: begin
                    if (in_q[idx]) pot <= acc_sum;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                FIRE: begin
                    if (fire) begin
                        pot       <= '0;
                        spike_out <= 1'b1;
                    end
`ifdef STDP_LEARN_EN
                    if (!(fire && learn_q)) done <= 1'b1;
`else
                    done <= 1'b1;
`endif
                end
`ifdef STDP_LEARN_EN
                LEARN: begin
                    weight[idx] <= w_nx;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: scenario tasks driving neuron_sched against an
// arithmetic model of potential and weights. Learning expectations follow
// STDP_LEARN_EN as compiled.
module tb_neuron_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic [7:0] inputs;
    logic       learn;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       busy, spike_out, done, overrun;
    logic [7:0] potential;

`ifdef STDP_LEARN_EN
    localparam bit LEARN_EN = 1'b1;
`else
    localparam bit LEARN_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_pot;
    int m_w [8];

    neuron_sched dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .inputs(inputs),
        .learn(learn), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .busy(busy), .spike_out(spike_out), .done(done),
        .potential(potential), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pot = 0;
        for (int i = 0; i < 8; i++) m_w[i] = 16;
    endfunction

    // One whole step from the rules: leak, sum with clamp, threshold, STDP
    function automatic bit model_step(input logic [7:0] in, input logic ln);
        bit fired;
        m_pot = m_pot - (m_pot / 4);
        for (int i = 0; i < 8; i++)
            if (in[i]) m_pot = (m_pot + m_w[i] > 255) ? 255 : m_pot + m_w[i];
        fired = (m_pot >= 128);
        if (fired) m_pot = 0;
        if (LEARN_EN && fired && ln)
            for (int i = 0; i < 8; i++)
                m_w[i] = in[i] ? ((m_w[i] == 255) ? 255 : m_w[i] + 1)
                               : ((m_w[i] == 0) ? 0 : m_w[i] - 1);
        return fired;
    endfunction

    function automatic int exp_done_k(input bit fired, input logic ln);
        return (LEARN_EN && fired && ln) ? 18 : 10;
    endfunction

    task automatic write_w(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(posedge clk); #1;
        w_we = 1'b0;
        m_w[a] = d;
    endtask

    // Drives one step and records what the DUT did; k counts edges after E0
    task automatic run_step(input logic [7:0] in, input logic ln,
                            input bit wr_now, input logic [2:0] wa, input logic [7:0] wd,
                            input int tick_at, input int wr_at,
                            output int spike_k, output int done_k,
                            output int spikes, output int dones,
                            output logic [7:0] pot9, output logic [7:0] pot_end);
        @(negedge clk);
        tick_in = 1'b1; inputs = in; learn = ln;
        w_we = wr_now; w_addr = wa; w_data = wd;
        @(posedge clk); #1;
        tick_in = 1'b0; w_we = 1'b0;
        inputs = 8'($urandom); learn = 1'($urandom);
        spike_k = -1; done_k = -1; spikes = 0; dones = 0; pot9 = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            tick_in = 1'b0; w_we = 1'b0;
            if (spike_out) begin spikes++; if (spike_k < 0) spike_k = k; end
            if (done) begin dones++; if (done_k < 0) done_k = k; end
            if (k == 9) pot9 = potential;
            if (done_k >= 0 && k >= done_k + 2) break;
            if (k == tick_at) tick_in = 1'b1;
            if (k == wr_at) begin w_we = 1'b1; w_addr = wa; w_data = wd; end
        end
        pot_end = potential;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick_in = 0; inputs = 0; learn = 0; w_we = 0; w_addr = 0; w_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (potential !== 8'd0) begin n_err++; $display("FAIL reset_pot: got %0d want 0", potential); end
        n_cmp++; if ({spike_out, done, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {spike_out, done, overrun}); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_fire_all();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        run_step(8'hFF, 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'hFF, 1'b0);
        n_cmp++; if (p9 !== 8'd128) begin n_err++; $display("FAIL fire_all_pot9: got %0d want 128", p9); end
        n_cmp++; if (sk !== 10 || sp !== 1) begin n_err++; $display("FAIL fire_all_spike: got k=%0d n=%0d want k=10 n=1", sk, sp); end
        n_cmp++; if (dk !== 10 || dn !== 1) begin n_err++; $display("FAIL fire_all_done: got k=%0d n=%0d want k=10 n=1", dk, dn); end
        n_cmp++; if (pe !== 8'(m_pot) || !f) begin n_err++; $display("FAIL fire_all_pot: got %0d want %0d", pe, m_pot); end
    endtask

    task automatic test_three_ticks();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        int want_pot [3] = '{64, 112, 0};
        for (int t = 0; t < 3; t++) begin
            run_step(8'h0F, 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
            f = model_step(8'h0F, 1'b0);
            n_cmp++; if (pe !== 8'(want_pot[t]) || pe !== 8'(m_pot)) begin n_err++; $display("FAIL three_ticks_pot%0d: got %0d want %0d", t, pe, want_pot[t]); end
            n_cmp++; if (sp !== ((t == 2) ? 1 : 0) || f !== (t == 2)) begin n_err++; $display("FAIL three_ticks_spike%0d: got %0d want %0d", t, sp, (t == 2) ? 1 : 0); end
        end
    endtask

    task automatic test_saturate();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        for (int i = 0; i < 8; i++) write_w(3'(i), 8'd255);
        run_step(8'hFF, 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'hFF, 1'b0);
        n_cmp++; if (p9 !== 8'd255) begin n_err++; $display("FAIL saturate_pot9: got %0d want 255", p9); end
        n_cmp++; if (sp !== 1 || pe !== 8'd0 || !f) begin n_err++; $display("FAIL saturate_fire: got n=%0d pot=%0d want n=1 pot=0", sp, pe); end
        for (int i = 0; i < 8; i++) write_w(3'(i), 8'd16);
    endtask

    task automatic test_learn();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        for (int i = 0; i < 4; i++) write_w(3'(i), 8'd64);
        run_step(8'h0F, 1'b1, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'h0F, 1'b1);
        n_cmp++; if (sk !== 10 || !f) begin n_err++; $display("FAIL learn_spike: got k=%0d want 10", sk); end
        n_cmp++; if (dk !== exp_done_k(f, 1'b1) || dn !== 1) begin n_err++; $display("FAIL learn_done: got k=%0d n=%0d want k=%0d n=1", dk, dn, exp_done_k(f, 1'b1)); end
        // probe each weight through a single-synapse step
        for (int i = 0; i < 8; i++) begin
            run_step(8'(1 << i), 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
            f = model_step(8'(1 << i), 1'b0);
            n_cmp++; if (pe !== 8'(m_pot)) begin n_err++; $display("FAIL learn_probe_w%0d: got pot %0d want %0d", i, pe, m_pot); end
        end
    endtask

    task automatic test_overrun();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        run_step(8'hA5, 1'b0, 0, 0, 0, 4, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'hA5, 1'b0);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
        n_cmp++; if (pe !== 8'(m_pot) || dk !== 10 || dn !== 1 || sp !== (f ? 1 : 0)) begin n_err++; $display("FAIL overrun_step: got pot=%0d dk=%0d dn=%0d sp=%0d want pot=%0d dk=10 dn=1 sp=%0d", pe, dk, dn, sp, m_pot, f ? 1 : 0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL overrun_restart: got busy %b want 0", busy); end
    endtask

    task automatic test_write_busy();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        run_step(8'h00, 1'b0, 0, 3'd1, 8'd200, -1, 3, sk, dk, sp, dn, p9, pe);
        f = model_step(8'h00, 1'b0);
        run_step(8'h02, 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'h02, 1'b0);
        n_cmp++; if (pe !== 8'(m_pot)) begin n_err++; $display("FAIL write_busy: got pot %0d want %0d", pe, m_pot); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_write_with_tick();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        m_w[5] = 100;
        run_step(8'h20, 1'b0, 1, 3'd5, 8'd100, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'h20, 1'b0);
        n_cmp++; if (pe !== 8'(m_pot) || sp !== (f ? 1 : 0)) begin n_err++; $display("FAIL write_with_tick: got pot=%0d sp=%0d want pot=%0d sp=%0d", pe, sp, m_pot, f ? 1 : 0); end
    endtask

    task automatic test_random();
        int sk, dk, sp, dn; logic [7:0] p9, pe, in, wd; logic ln; bit f, wr; logic [2:0] wa;
        for (int n = 0; n < 30; n++) begin
            in = 8'($urandom); ln = 1'($urandom);
            wr = ($urandom_range(0, 3) == 0); wa = 3'($urandom); wd = 8'($urandom_range(0, 80));
            if (wr) m_w[wa] = wd;
            run_step(in, ln, wr, wa, wd, -1, -1, sk, dk, sp, dn, p9, pe);
            f = model_step(in, ln);
            n_cmp++; if (pe !== 8'(m_pot)) begin n_err++; $display("FAIL random%0d_pot: got %0d want %0d", n, pe, m_pot); end
            n_cmp++; if (dk !== exp_done_k(f, ln) || sp !== (f ? 1 : 0)) begin n_err++; $display("FAIL random%0d_timing: got dk=%0d sp=%0d want dk=%0d sp=%0d", n, dk, sp, exp_done_k(f, ln), f ? 1 : 0); end
        end
    endtask

    task automatic test_reset_mid();
        int sk, dk, sp, dn; logic [7:0] p9, pe; bit f;
        int pulses = 0;
        @(negedge clk);
        tick_in = 1'b1; inputs = 8'hFF;
        @(posedge clk); #1; tick_in = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || potential !== 8'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_mid_state: got busy=%b pot=%0d ovr=%b want 0 0 0", busy, potential, overrun); end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (spike_out || done) pulses++;
        end
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (spike_out || done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL reset_mid_pulses: got %0d want 0", pulses); end
        model_reset();
        run_step(8'hFF, 1'b0, 0, 0, 0, -1, -1, sk, dk, sp, dn, p9, pe);
        f = model_step(8'hFF, 1'b0);
        n_cmp++; if (p9 !== 8'd128 || sk !== 10 || !f) begin n_err++; $display("FAIL reset_mid_weights: got pot9=%0d k=%0d want 128 10", p9, sk); end
    endtask

    initial begin
        test_reset();
        test_fire_all();
        test_three_ticks();
        test_saturate();
        test_learn();
        test_overrun();
        test_write_busy();
        test_write_with_tick();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
